// File: rtl/prbs_checker_pkg.sv
// Shared definitions for the board PRNG generator and the prbs_checker receiver:
// default LFSR width/taps, FSM state encoding and a counter-width helper.
package prbs_checker_pkg;

  localparam int                   DEF_WIDTH    = 4;
  // x^4+x^3+1: next bit = b[0] ^ b[3]
  localparam logic [DEF_WIDTH-1:0] DEF_TAP_MASK = 4'b1001;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prng_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module prng_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             BTN_N,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge CLK or negedge BTN_N) begin
    if (!BTN_N) begin
      q <= '0;
    end else if (clr) begin
      // NOTE: clear is tested first so a coincident increment is dropped, leaving 0.
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS receiver: fills a local predictor, locks after a run of
// matches, counts bit errors while locked. Optional STUCK_DETECT_EN adds all-zero detection.
module prbs_checker
  import prbs_checker_pkg::*;
#(
  parameter int               WIDTH    = DEF_WIDTH,
  parameter logic [WIDTH-1:0] TAP_MASK = DEF_TAP_MASK,
  parameter int               LOCK_CNT = 8,
  parameter int               LOSS_CNT = 4,
  parameter int               ERR_W    = 16
) (
  input  logic             CLK,
  input  logic             BTN_N,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             LEDG_N,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             stuck
);

  localparam int FW = cnt_w(WIDTH);
  localparam int MW = cnt_w(LOCK_CNT);
  localparam int SW = cnt_w(LOSS_CNT);

  localparam logic [FW-1:0] FILL_LAST  = FW'(WIDTH - 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
  localparam logic [SW-1:0] MISS_LAST  = SW'(LOSS_CNT - 1);

  state_e           state;
  logic [WIDTH-1:0] r;
  logic [FW-1:0]    fill_cnt;
  logic [MW-1:0]    match_cnt;
  logic [SW-1:0]    miss_cnt;

  logic pred;
  logic mis;
  logic err_inc;

  assign pred    = ^(r & TAP_MASK);
  assign mis     = din ^ pred;
  assign err_inc = din_valid && (state == ST_LOCKED) && mis;
  assign LEDG_N  = ~locked;

`ifdef STUCK_DETECT_EN
  localparam int            ZW        = $clog2(2 * WIDTH + 1);
  localparam logic [ZW-1:0] ZERO_TRIP = ZW'(2 * WIDTH);

  logic [ZW-1:0] zero_run;
  logic [ZW-1:0] zero_next;
  logic          zero_hit;

  always_comb begin
    zero_next = zero_run;
    if (din) begin
      zero_next = '0;
    end else if (zero_run != ZERO_TRIP) begin
      zero_next = zero_run + 1'b1;
    end
  end

  assign zero_hit = (zero_next == ZERO_TRIP);
`else
  assign stuck = 1'b0;
`endif

  always_ff @(posedge CLK or negedge BTN_N) begin
    if (!BTN_N) begin
      state     <= ST_FILL;
      r         <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
`ifdef STUCK_DETECT_EN
      zero_run  <= '0;
      stuck     <= 1'b0;
`endif
    end else begin
      // NOTE: default-then-override keeps err_pulse a single-cycle strobe without extra logic.
      err_pulse <= 1'b0;
      if (din_valid) begin
        r <= {r[WIDTH-2:0], din};
        case (state)
          ST_FILL: begin
            if (fill_cnt == FILL_LAST) begin
              state     <= ST_TRACK;
              fill_cnt  <= '0;
              match_cnt <= '0;
            end else begin
              fill_cnt <= fill_cnt + 1'b1;
            end
          end
          ST_TRACK: begin
            if (mis) begin
              match_cnt <= '0;
            end else if (match_cnt == MATCH_LAST) begin
              state    <= ST_LOCKED;
              locked   <= 1'b1;
              miss_cnt <= '0;
            end else begin
              match_cnt <= match_cnt + 1'b1;
            end
          end
          ST_LOCKED: begin
            if (mis) begin
              err_pulse <= 1'b1;
              if (miss_cnt == MISS_LAST) begin
                state     <= ST_TRACK;
                locked    <= 1'b0;
                match_cnt <= '0;
              end else begin
                miss_cnt <= miss_cnt + 1'b1;
              end
            end else begin
              miss_cnt <= '0;
            end
          end
          default: begin
            state  <= ST_FILL;
            locked <= 1'b0;
          end
        endcase
`ifdef STUCK_DETECT_EN
        // A dead line overrides whatever the FSM decided this bit.
        zero_run <= zero_next;
        stuck    <= zero_hit;
        if (zero_hit) begin
          state     <= ST_FILL;
          fill_cnt  <= '0;
          match_cnt <= '0;
          miss_cnt  <= '0;
          locked    <= 1'b0;
        end
`endif
      end
    end
  end

  prng_sat_counter #(
    .WIDTH (ERR_W)
  ) u_err_cnt (
    .CLK   (CLK),
    .BTN_N (BTN_N),
    .inc   (err_inc),
    .clr   (clr_cnt),
    .q     (err_count)
  );

endmodule

// File: tb/tb_prbs_checker.sv
// Self-checking bench for prbs_checker: directed scenarios plus a randomized stream,
// compared every cycle against a bit-history reference model.
module tb_prbs_checker;

  localparam int         WIDTH    = 4;
  localparam logic [3:0] TAPS     = 4'b1001;
  localparam int         LOCK_CNT = 8;
  localparam int         LOSS_CNT = 4;
  localparam int         ERR_W    = 4;
  localparam int         ERR_MAX  = (1 << ERR_W) - 1;

  logic             CLK = 1'b0;
  logic             BTN_N;
  logic             din;
  logic             din_valid;
  logic             clr_cnt;
  logic             locked;
  logic             LEDG_N;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic             stuck;

  always #5 CLK = ~CLK;

  prbs_checker #(
    .WIDTH    (WIDTH),
    .TAP_MASK (TAPS),
    .LOCK_CNT (LOCK_CNT),
    .LOSS_CNT (LOSS_CNT),
    .ERR_W    (ERR_W)
  ) dut (
    .CLK       (CLK),
    .BTN_N     (BTN_N),
    .din       (din),
    .din_valid (din_valid),
    .clr_cnt   (clr_cnt),
    .locked    (locked),
    .LEDG_N    (LEDG_N),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .stuck     (stuck)
  );

  int    checks   = 0;
  int    failures = 0;
  string phase    = "init";

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode 0 = filling, 1 = tracking, 2 = locked.
  bit hist[$];
  int m_mode, m_fill, m_match, m_miss, m_cnt, m_zero;
  bit m_pulse, m_stuck;

  task automatic model_reset();
    hist.delete();
    m_mode = 0; m_fill = 0; m_match = 0; m_miss = 0; m_cnt = 0; m_zero = 0;
    m_pulse = 1'b0; m_stuck = 1'b0;
  endtask

  task automatic model_step(input bit d, input bit v, input bit c);
    bit pred, mis;
    m_pulse = 1'b0;
    if (v) begin
      // Missing history counts as zero, matching a cleared shift register.
      pred = 1'b0;
      for (int i = 0; i < WIDTH; i++)
        if (TAPS[i] && hist.size() > i) pred ^= hist[hist.size() - 1 - i];
      mis = d ^ pred;
      hist.push_back(d);
      if (hist.size() > WIDTH) void'(hist.pop_front());
      if (m_mode == 2 && mis) begin
        m_pulse = 1'b1;
        if (m_cnt < ERR_MAX) m_cnt++;
      end
      case (m_mode)
        0: begin
          m_fill++;
          if (m_fill == WIDTH) begin m_mode = 1; m_fill = 0; m_match = 0; end
        end
        1: begin
          if (mis) m_match = 0;
          else begin
            m_match++;
            if (m_match == LOCK_CNT) begin m_mode = 2; m_miss = 0; end
          end
        end
        default: begin
          if (mis) begin
            m_miss++;
            if (m_miss == LOSS_CNT) begin m_mode = 1; m_match = 0; end
          end else m_miss = 0;
        end
      endcase
`ifdef STUCK_DETECT_EN
      if (d) m_zero = 0;
      else if (m_zero < 2 * WIDTH) m_zero++;
      m_stuck = (m_zero == 2 * WIDTH);
      if (m_stuck) begin m_mode = 0; m_fill = 0; m_match = 0; m_miss = 0; end
`endif
    end
    if (c) m_cnt = 0;
  endtask

  task automatic compare_all();
    check({phase, ".locked"},    locked,    (m_mode == 2));
    check({phase, ".ledg_n"},    LEDG_N,    (m_mode != 2));
    check({phase, ".err_pulse"}, err_pulse, m_pulse);
    check({phase, ".err_count"}, err_count, m_cnt);
    check({phase, ".stuck"},     stuck,     m_stuck);
  endtask

  task automatic step(input bit d, input bit v, input bit c);
    @(negedge CLK);
    din = d; din_valid = v; clr_cnt = c;
    @(posedge CLK);
    model_step(d, v, c);
    #1;
    compare_all();
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    #2 BTN_N = 1'b0;
    model_reset();
    #1 compare_all();
    @(negedge CLK);
    din = 1'b0; din_valid = 1'b0; clr_cnt = 1'b0;
    BTN_N = 1'b1;
  endtask

  // Board generator: each new bit is the tap-parity of the previous WIDTH bits.
  bit g[$];

  task automatic gen_seed(input logic [3:0] s);
    g.delete();
    for (int i = WIDTH - 1; i >= 0; i--) g.push_back(s[i]);
  endtask

  function automatic bit gen_next();
    bit nb = 1'b0;
    for (int i = 0; i < WIDTH; i++)
      if (TAPS[i]) nb ^= g[g.size() - 1 - i];
    g.push_back(nb);
    void'(g.pop_front());
    return nb;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bit [4:0] pat;
    int       lock_at;
    BTN_N = 1'b1; din = 1'b0; din_valid = 1'b0; clr_cnt = 1'b0;
    model_reset();

    phase = "reset";
    apply_reset();

    // Lock onto the generator stream from seed F.
    phase = "t1";
    gen_seed(4'hF);
    for (int i = 0; i < 12; i++) begin
      step(gen_next(), 1'b1, 1'b0);
      if (i == 10) check("t1.not_yet_locked", locked, 1'b0);
    end
    check("t1.locked", locked, 1'b1);
    check("t1.ledg_n", LEDG_N, 1'b0);
    check("t1.err_count", err_count, 0);
    for (int i = 0; i < 6; i++) step(gen_next(), 1'b1, 1'b0);

    // One inverted bit propagates to offsets 0, 1 and 4.
    phase = "t2";
    pat = '0;
    for (int i = 0; i < 8; i++) begin
      step((i == 0) ? ~gen_next() : gen_next(), 1'b1, 1'b0);
      if (i < 5) pat[i] = err_pulse;
    end
    check("t2.pulse_offsets", pat, 5'b10011);
    check("t2.err_count", err_count, 3);
    check("t2.locked", locked, 1'b1);

    // Stuck-high line drops lock; the stream relocks within 12 bits.
    phase = "t3";
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0);
    check("t3.dropped", locked, 1'b0);
    lock_at = 0;
    for (int i = 1; i <= 12; i++) begin
      step(gen_next(), 1'b1, 1'b0);
      if (lock_at == 0 && locked) lock_at = i;
    end
    check("t3.relocked", locked, 1'b1);
    check("t3.relock_in_12", (lock_at >= 1 && lock_at <= 12), 1'b1);

    // Invalid cycles freeze everything.
    phase = "t4";
    for (int i = 0; i < 10; i++) step(i[0], 1'b0, 1'b0);
    check("t4.locked_held", locked, 1'b1);
    check("t4.count_held", err_count, m_cnt);
    for (int i = 0; i < 4; i++) step(gen_next(), 1'b1, 1'b0);

    // Saturation, clear-vs-increment priority, async reset mid-TRACK.
    phase = "t5";
    step(gen_next(), 1'b1, 1'b1);
    check("t5.cleared", err_count, 0);
    for (int e = 0; e < 20; e++) begin
      step(~gen_next(), 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) step(gen_next(), 1'b1, 1'b0);
    end
    check("t5.saturated", err_count, ERR_MAX);
    check("t5.still_locked", locked, 1'b1);
    step(~gen_next(), 1'b1, 1'b1);
    check("t5.clr_pulse", err_pulse, 1'b1);
    check("t5.clr_wins", err_count, 0);
    for (int i = 0; i < 6; i++) step(gen_next(), 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0);
    check("t5.in_track", locked, 1'b0);
    phase = "t5.reset";
    apply_reset();
    check("t5.reset_ledg", LEDG_N, 1'b1);
    check("t5.reset_count", err_count, 0);

    // All-zero line.
    phase = "t6";
`ifdef STUCK_DETECT_EN
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0);
    check("t6.stuck", stuck, 1'b1);
    check("t6.unlocked", locked, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("t6.stuck_clear", stuck, 1'b0);
`else
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0);
    check("t6.zero_locks", locked, 1'b1);
    check("t6.no_stuck", stuck, 1'b0);
`endif

    // Randomized stream: gaps, flips, clears and zero bursts.
    phase = "rand";
    apply_reset();
    gen_seed(4'($urandom_range(1, 15)));
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        for (int z = 0; z < 10; z++) step(1'b0, 1'b1, 1'b0);
      end else begin
        bit v, d, c;
        v = ($urandom_range(0, 3) != 0);
        c = ($urandom_range(0, 49) == 0);
        if (v) begin
          d = gen_next();
          if ($urandom_range(0, 29) == 0) d = ~d;
        end else begin
          d = 1'($urandom_range(0, 1));
        end
        step(d, v, c);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
